// File: rtl/video_pixel_unpacker.sv
// Video pixel unpacker: splits packed FIFO words into pixels, expands
// colour depth and re-locks to frame blanking after a FIFO underflow.
module video_pixel_unpacker #(
    parameter int WORD_WIDTH = 64,
    parameter int PIXEL_BITS = 16,
    parameter int COLOR_BITS = 5,
    parameter int OUT_BITS   = 8,
    parameter int CNT_BITS   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_empty,
    output logic                  word_rd,
    input  logic                  video_enable,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic                  flip,
    output logic [3*OUT_BITS-1:0] rgb_out,
    output logic                  de_out,
    output logic                  locked,
    output logic [CNT_BITS-1:0]   underflow_count
);
    localparam int PPW   = WORD_WIDTH / PIXEL_BITS;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(PPW - 1);
    localparam int CB = COLOR_BITS;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      slot;
    logic                  flip_q, flip_d;
    logic [3*OUT_BITS-1:0] rgb_q, rgb_d;
    logic                  de_q;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  rd_c;
    logic [PIXEL_BITS-1:0] pix_a [PPW];
    logic [PIXEL_BITS-1:0] pix;

    // MSB replication: the top OUT_BITS of {c, c}.
    function automatic logic [OUT_BITS-1:0] expand(
        input logic [CB-1:0] c
    );
        logic [2*CB-1:0] rep;
        rep = {c, c};
        return rep[2*CB-1 -: OUT_BITS];
    endfunction

    always_comb begin
        for (int i = 0; i < PPW; i++) begin
            pix_a[i] = word_data[i*PIXEL_BITS +: PIXEL_BITS];
        end
    end

    assign slot = flip_q ? (LAST - idx_q) : idx_q;
    assign pix  = pix_a[slot];

    if (PIXEL_BITS > 3*CB) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^pix[PIXEL_BITS-1:3*CB];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flip_d  = flip_q;
        cnt_d   = cnt_q;
        rgb_d   = '0;
        rd_c    = 1'b0;
        unique case (state_q)
            UNLOCKED: begin
                if (hblank && vblank && !word_empty) begin
                    state_d = LOCKED;
                    idx_d   = '0;
                    flip_d  = flip;
                end
            end
            LOCKED: begin
                if (video_enable) begin
                    if (word_empty) begin
                        state_d = UNLOCKED;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        rgb_d = {expand(pix[3*CB-1:2*CB]),
                                 expand(pix[2*CB-1:CB]),
                                 expand(pix[CB-1:0])};
                        if (idx_q == LAST) begin
                            rd_c   = 1'b1;
                            idx_d  = '0;
                            flip_d = flip;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // A word caught mid-way by reset is abandoned, never popped.
    assign word_rd = rd_c & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= UNLOCKED;
            idx_q   <= '0;
            flip_q  <= 1'b0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flip_q  <= flip_d;
            rgb_q   <= rgb_d;
            de_q    <= video_enable;
            cnt_q   <= cnt_d;
        end
    end

    assign rgb_out         = rgb_q;
    assign de_out          = de_q;
    assign locked          = (state_q == LOCKED);
    assign underflow_count = cnt_q;
endmodule

// File: tb/tb_video_pixel_unpacker.sv
// Self-checking bench for video_pixel_unpacker with default parameters.
module tb_video_pixel_unpacker;
    localparam logic [63:0] WORD_A = 64'h7FFF_0000_001F_7C00;
    localparam logic [63:0] WORD_B = 64'h1234_5678_2AF3_4E71;
    localparam logic [63:0] WORD_C = 64'h0421_7FE0_03FF_5555;
    localparam logic [63:0] WORD_D = 64'h2222_6318_1CE7_0C63;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] word_data;
    logic        word_empty;
    logic        word_rd;
    logic        video_enable;
    logic        hblank;
    logic        vblank;
    logic        flip;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        locked;
    logic [7:0]  underflow_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [24:0] exp_q[$];

    always #5 clock = ~clock;

    video_pixel_unpacker dut (
        .clock           (clock),
        .reset           (reset),
        .word_data       (word_data),
        .word_empty      (word_empty),
        .word_rd         (word_rd),
        .video_enable    (video_enable),
        .hblank          (hblank),
        .vblank          (vblank),
        .flip            (flip),
        .rgb_out         (rgb_out),
        .de_out          (de_out),
        .locked          (locked),
        .underflow_count (underflow_count)
    );

    // Reference colour: 5-bit channel c becomes (c<<3)|(c>>2).
    function automatic logic [23:0] model_rgb(input logic [15:0] p);
        logic [7:0] r, g, b;
        r = 8'(p[14:10]);
        g = 8'(p[9:5]);
        b = 8'(p[4:0]);
        r = (r << 3) | (r >> 2);
        g = (g << 3) | (g >> 2);
        b = (b << 3) | (b >> 2);
        return {r, g, b};
    endfunction

    function automatic logic [15:0] slot_of(input logic [63:0] w,
                                            input int s);
        return 16'(w >> (16 * s));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic hb, input logic vb,
                         input logic emp, input logic [63:0] d,
                         input logic fl);
        video_enable = en;
        hblank       = hb;
        vblank       = vb;
        word_empty   = emp;
        word_data    = d;
        flip         = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic lock(input logic [63:0] d, input logic fl);
        drive(1'b0, 1'b1, 1'b1, 1'b0, d, fl);
        step();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, WORD_A, 1'b0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (word_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rd: word_rd=%b want 0", word_rd);
        end
        step();
        step();
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_locked: got %b want 0", locked);
        end
        n_cmp++;
        if (rgb_out !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_rgb: got %h want 000000", rgb_out);
        end
        n_cmp++;
        if (de_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_de: got %b want 0", de_out);
        end
        n_cmp++;
        if (underflow_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d want 0", underflow_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_decode(input logic fl);
        logic [23:0] exp_c [4] = '{24'hFF0000, 24'h0000FF,
                                   24'h000000, 24'hFFFFFF};
        logic [24:0] e;
        do_reset();
        lock(WORD_A, fl);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL decode_lock: locked=%b want 1", locked);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, WORD_A, fl);
            exp_q.push_back({1'b1, exp_c[fl ? 3 - i : i]});
            #1;
            n_cmp++;
            if (word_rd !== (i == 3)) begin
                n_bad++;
                $display("FAIL decode_rd[%0d] flip=%b: got %b want %b",
                         i, fl, word_rd, (i == 3));
            end
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({de_out, rgb_out} !== e) begin
                n_bad++;
                $display("FAIL decode_px[%0d] flip=%b: de/rgb=%b/%h want %b/%h",
                         i, fl, de_out, rgb_out, e[24], e[23:0]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
        exp_q.push_back({1'b0, 24'h0});
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if ({de_out, rgb_out} !== e) begin
            n_bad++;
            $display("FAIL decode_idle: de/rgb=%b/%h want %b/%h",
                     de_out, rgb_out, e[24], e[23:0]);
        end
    endtask

    task automatic test_expand();
        do_reset();
        lock(64'h0000_0000_0000_4210, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_4210, 1'b0);
        step();
        n_cmp++;
        if (rgb_out !== 24'h848484) begin
            n_bad++;
            $display("FAIL expand_4210: got %h want 848484", rgb_out);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        lock(WORD_A, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, WORD_A, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, WORD_A, 1'b0);
        #1;
        n_cmp++;
        if (word_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL uflow_rd: got %b want 0", word_rd);
        end
        step();
        n_cmp++;
        if ({locked, underflow_count, rgb_out} !== {1'b0, 8'd1, 24'h0}) begin
            n_bad++;
            $display("FAIL uflow_state: locked/cnt/rgb=%b/%0d/%h want 0/1/000000",
                     locked, underflow_count, rgb_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i != 1, i == 1, 1'b0, WORD_B, 1'b0);
            #1;
            n_cmp++;
            if (word_rd !== 1'b0) begin
                n_bad++;
                $display("FAIL unlocked_rd[%0d]: got %b want 0", i, word_rd);
            end
            step();
            n_cmp++;
            if ({locked, rgb_out} !== {1'b0, 24'h0}) begin
                n_bad++;
                $display("FAIL unlocked_hold[%0d]: locked/rgb=%b/%h want 0/000000",
                         i, locked, rgb_out);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, WORD_B, 1'b0);
        step();
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL relock_empty: locked=%b want 0", locked);
        end
        lock(WORD_B, 1'b0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: locked=%b want 1", locked);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, WORD_B, 1'b0);
        step();
        n_cmp++;
        if (rgb_out !== model_rgb(slot_of(WORD_B, 0))) begin
            n_bad++;
            $display("FAIL relock_slot0: got %h want %h",
                     rgb_out, model_rgb(slot_of(WORD_B, 0)));
        end
    endtask

    task automatic test_saturation();
        logic [7:0] want;
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            lock(WORD_A, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b1, WORD_A, 1'b0);
            step();
            want = (k > 255) ? 8'd255 : 8'(k);
            n_cmp++;
            if (underflow_count !== want) begin
                n_bad++;
                $display("FAIL sat_cnt[%0d]: got %0d want %0d",
                         k, underflow_count, want);
            end
        end
    endtask

    task automatic test_reset_midword();
        for (int stop = 2; stop <= 3; stop++) begin
            do_reset();
            lock(WORD_A, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b1, WORD_A, 1'b0);
            step();
            lock(WORD_A, 1'b0);
            for (int i = 0; i < stop; i++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, WORD_A, 1'b0);
                step();
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0, WORD_A, 1'b0);
            reset = 1'b1;
            #1;
            n_cmp++;
            if (word_rd !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_rd[idx=%0d]: got %b want 0", stop, word_rd);
            end
            step();
            n_cmp++;
            if ({locked, underflow_count, rgb_out} !== {1'b0, 8'd0, 24'h0}) begin
                n_bad++;
                $display("FAIL midrst_state[idx=%0d]: locked/cnt/rgb=%b/%0d/%h want 0/0/000000",
                         stop, locked, underflow_count, rgb_out);
            end
            reset = 1'b0;
        end
    endtask

    task automatic test_midflip();
        logic [63:0] w;
        logic        fl;
        int          s;
        logic [24:0] e;
        do_reset();
        lock(WORD_C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w  = (i < 4) ? WORD_C : WORD_D;
            fl = (i >= 1) && (i != 5);
            s  = (i < 4) ? i : 7 - i;
            drive(1'b1, 1'b0, 1'b0, 1'b0, w, fl);
            exp_q.push_back({1'b1, model_rgb(slot_of(w, s))});
            #1;
            n_cmp++;
            if (word_rd !== (i % 4 == 3)) begin
                n_bad++;
                $display("FAIL midflip_rd[%0d]: got %b want %b",
                         i, word_rd, (i % 4 == 3));
            end
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({de_out, rgb_out} !== e) begin
                n_bad++;
                $display("FAIL midflip_px[%0d]: de/rgb=%b/%h want %b/%h",
                         i, de_out, rgb_out, e[24], e[23:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        logic        mflip;
        logic        fl;
        logic [24:0] e;
        do_reset();
        mflip = 1'($urandom_range(0, 1));
        w     = {$urandom, $urandom};
        lock(w, mflip);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, w, 1'($urandom_range(0, 1)));
                    exp_q.push_back({1'b0, 24'h0});
                    step();
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({de_out, rgb_out} !== e) begin
                        n_bad++;
                        $display("FAIL b2b_gap[%0d.%0d]: de/rgb=%b/%h want 0/000000",
                                 k, i, de_out, rgb_out);
                    end
                end
                fl = 1'($urandom_range(0, 1));
                drive(1'b1, 1'b0, 1'b0, 1'b0, w, fl);
                exp_q.push_back({1'b1,
                                 model_rgb(slot_of(w, mflip ? 3 - i : i))});
                #1;
                n_cmp++;
                if (word_rd !== (i == 3)) begin
                    n_bad++;
                    $display("FAIL b2b_rd[%0d.%0d]: got %b want %b",
                             k, i, word_rd, (i == 3));
                end
                step();
                e = exp_q.pop_front();
                n_cmp++;
                if ({de_out, rgb_out} !== e) begin
                    n_bad++;
                    $display("FAIL b2b_px[%0d.%0d]: de/rgb=%b/%h want %b/%h",
                             k, i, de_out, rgb_out, e[24], e[23:0]);
                end
            end
            mflip = fl;
            w     = {$urandom, $urandom};
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
        test_reset();
        test_decode(1'b0);
        test_decode(1'b1);
        test_expand();
        test_underflow();
        test_saturation();
        test_reset_midword();
        test_midflip();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
